ps2_key_filter: RTL and testbench

Sits between `PS2_Controller` and `controlpath`. It turns the raw PS/2 Set-2 byte stream into one clean event per physical key press. It strips break (F0) sequences, extended (E0) prefixes, Pause (E1) sequences, device status bytes and typematic repeats. `key_valid`/`key_code` drive `controlpath` inputs `ps2_key_pressed`/`ps2_key_data`, so a key release can never be mistaken for a menu or note selection.

---
 rtl/ps2_key_filter_if.sv | 38 +++
 rtl/ps2_key_filter.sv | 197 +++++++++++++++++++
 tb/tb_ps2_key_filter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_filter_if.sv
// ps2_key_filter_if
//   Groups the byte-strobe input side and the key-event output side of
//   ps2_key_filter into one bundle.
//   master : byte source (PS/2 receiver side), reads key events back
//   slave  : the filter itself
// Signals:
//   ps2_key_data     [7:0] received byte, valid while ps2_key_pressed=1
//   ps2_key_pressed        single-cycle strobe per received byte
//   key_code         [7:0] make code of the last accepted press
//   key_extended           1 if that press carried the E0 prefix
//   key_valid              single-cycle pulse per accepted press
//   key_held               1 while the last accepted key is still down
interface ps2_key_filter_if;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_valid;
    logic       key_held;

    modport master (
        output ps2_key_data,
        output ps2_key_pressed,
        input  key_code,
        input  key_extended,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  ps2_key_data,
        input  ps2_key_pressed,
        output key_code,
        output key_extended,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/ps2_key_filter.sv
// ps2_key_filter
//   Turns the raw PS/2 Set-2 byte stream into one event per physical key
//   press. Break (F0) sequences, E0 prefixes, Pause (E1) sequences, device
//   status bytes and (optionally) typematic repeats are stripped.
// Parameters:
//   TIMEOUT_CYCLES  idle cycles after which a partial prefix is abandoned
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset     synchronous active-high reset
//   bus       ps2_key_filter_if.slave (byte strobe in, key events out)
// Build option:
//   KEY_REPEAT_FILTER_EN  when defined, a make matching the held key is
//                         suppressed as a typematic repeat
//
// state        | meaning
// -------------+--------------------------------------------------
// S_IDLE       | no prefix pending
// S_EXT        | E0 seen, waiting for code or F0
// S_BRK        | F0 seen, next byte is a released key
// S_EXT_BRK    | E0 F0 seen, next byte is a released extended key
// S_PAUSE_SKIP | inside the E1 Pause sequence, swallowing bytes
module ps2_key_filter #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    ps2_key_filter_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE_SKIP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [2:0]       skip_q, skip_d;
    logic [7:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [7:0]       hcode_q, hcode_d;
    logic             hext_q, hext_d;

    logic             expire;
    state_t           cur_state;
    logic             make_ev;
    logic             brk_ev;
    logic             ev_ext;
    logic             same_as_held;
    logic             pulse;

    wire [7:0] byte_in = bus.ps2_key_data;
    wire       strobe  = bus.ps2_key_pressed;

    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            skip_q  <= '0;
            code_q  <= '0;
            ext_q   <= 1'b0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            hcode_q <= '0;
            hext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            skip_q  <= skip_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            hcode_q <= hcode_d;
            hext_q  <= hext_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        skip_d  = skip_q;
        code_d  = code_q;
        ext_d   = ext_q;
        valid_d = 1'b0;
        held_d  = held_q;
        hcode_d = hcode_q;
        hext_d  = hext_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        ev_ext  = 1'b0;

        // An expiring prefix is treated as already gone, so a strobe landing
        // on the expiry cycle is decoded from idle.
        expire    = (state_q != S_IDLE) && (tmo_q == CNT_LAST);
        cur_state = expire ? S_IDLE : state_q;

        if (strobe) begin
            tmo_d   = '0;
            state_d = S_IDLE;
            case (cur_state)
                S_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (byte_in == 8'hE1) begin
                        state_d = S_PAUSE_SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_status(byte_in)) begin
                        make_ev = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (byte_in == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_in != 8'h12) begin
                        make_ev = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                S_BRK: begin
                    // A prefix byte here is a protocol error; restart on it.
                    if (byte_in == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_d = S_BRK;
                    end else begin
                        brk_ev = 1'b1;
                    end
                end
                S_EXT_BRK: begin
                    if (byte_in != 8'h12) begin
                        brk_ev = 1'b1;
                        ev_ext = 1'b1;
                    end
                end
                S_PAUSE_SKIP: begin
                    skip_d  = skip_q - 3'd1;
                    state_d = (skip_q <= 3'd1) ? S_IDLE : S_PAUSE_SKIP;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expire) begin
            state_d = S_IDLE;
            tmo_d   = '0;
        end else if (state_q != S_IDLE) begin
            tmo_d = tmo_q + CNT_W'(1);
        end else begin
            tmo_d = '0;
        end

        same_as_held = (hcode_q == byte_in) && (hext_q == ev_ext);

`ifdef KEY_REPEAT_FILTER_EN
        pulse = make_ev && !(held_q && same_as_held);
`else
        pulse = make_ev;
`endif

        if (pulse) begin
            valid_d = 1'b1;
            code_d  = byte_in;
            ext_d   = ev_ext;
        end

        if (make_ev) begin
            hcode_d = byte_in;
            hext_d  = ev_ext;
            held_d  = 1'b1;
        end

        if (brk_ev && same_as_held) begin
            held_d = 1'b0;
        end
    end

    assign bus.key_code     = code_q;
    assign bus.key_extended = ext_q;
    assign bus.key_valid    = valid_q;
    assign bus.key_held     = held_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// tb_ps2_key_filter
//   Directed scenarios from the key-filter behaviour plus a randomized byte
//   stream compared against a prefix-flag reference model.
module tb_ps2_key_filter;

    localparam int TMO = 16;

`ifdef KEY_REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_filter_if bus_if ();

    ps2_key_filter #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus_if)
    );

    int n_total = 0;
    int n_pass  = 0;
    int pulses  = 0;

    // Reference model: pending-prefix flags and a skip budget
    int         m_cyc = 0;
    int         m_last = 0;
    bit         m_ext_pend, m_brk_pend;
    int         m_skip;
    logic [7:0] m_code;
    logic       m_ext, m_valid, m_held;
    logic [7:0] m_hcode;
    logic       m_hext;

    function automatic bit status_byte(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

    task automatic m_make(input logic [7:0] b, input logic e);
        bit rep;
        rep = m_held && (m_hcode == b) && (m_hext == e);
        if (!FILTER || !rep) begin
            m_valid = 1'b1;
            m_code  = b;
            m_ext   = e;
        end
        m_hcode = b;
        m_hext  = e;
        m_held  = 1'b1;
    endtask

    task automatic m_break(input logic [7:0] b, input logic e);
        if (m_hcode == b && m_hext == e) m_held = 1'b0;
    endtask

    task automatic m_idle(input logic [7:0] b);
        if (b == 8'hE0)          m_ext_pend = 1;
        else if (b == 8'hF0)     m_brk_pend = 1;
        else if (b == 8'hE1)     m_skip = 7;
        else if (!status_byte(b)) m_make(b, 1'b0);
    endtask

    task automatic model_step(input logic r, input logic p, input logic [7:0] b);
        m_cyc++;
        m_valid = 1'b0;
        if (r) begin
            m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
            m_code = 0; m_ext = 0; m_held = 0; m_hcode = 0; m_hext = 0;
            m_last = m_cyc;
            return;
        end
        if ((m_ext_pend || m_brk_pend || m_skip > 0) && (m_cyc - m_last >= TMO)) begin
            m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
        end
        if (!p) return;
        m_last = m_cyc;
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_ext_pend && m_brk_pend) begin
            m_ext_pend = 0; m_brk_pend = 0;
            if (b != 8'h12) m_break(b, 1'b1);
        end else if (m_brk_pend) begin
            m_brk_pend = 0;
            if (b == 8'hE0 || b == 8'hF0) m_idle(b);
            else m_break(b, 1'b0);
        end else if (m_ext_pend) begin
            if (b == 8'hF0) m_brk_pend = 1;
            else if (b == 8'hE0) m_ext_pend = 1;
            else begin
                m_ext_pend = 0;
                if (b != 8'h12) m_make(b, 1'b1);
            end
        end else begin
            m_idle(b);
        end
    endtask

    // Drives one clock cycle of inputs, advances the model, then leaves time
    // just past the rising edge so outputs reflect this cycle's inputs.
    task automatic tick(input logic r, input logic p, input logic [7:0] d);
        @(negedge clk);
        rst = r;
        bus_if.ps2_key_pressed = p;
        bus_if.ps2_key_data    = d;
        model_step(r, p, d);
        @(posedge clk);
        #1;
        if (bus_if.key_valid === 1'b1) pulses++;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        n_total++;
        if ({bus_if.key_valid, bus_if.key_code, bus_if.key_extended, bus_if.key_held} !== 11'h0)
            $display("FAIL reset_outputs: got v=%b c=%h e=%b h=%b, want all 0",
                     bus_if.key_valid, bus_if.key_code, bus_if.key_extended, bus_if.key_held);
        else n_pass++;
    endtask

    task automatic test_single_make();
        send(8'h1C);
        n_total++;
        if (bus_if.key_valid !== 1'b1 || bus_if.key_code !== 8'h1C ||
            bus_if.key_extended !== 1'b0 || bus_if.key_held !== 1'b1)
            $display("FAIL single_make: got v=%b c=%h e=%b h=%b, want v=1 c=1c e=0 h=1",
                     bus_if.key_valid, bus_if.key_code, bus_if.key_extended, bus_if.key_held);
        else n_pass++;
        idle(1);
        n_total++;
        if (bus_if.key_valid !== 1'b0 || bus_if.key_code !== 8'h1C)
            $display("FAIL single_pulse_width: got v=%b c=%h, want v=0 c=1c",
                     bus_if.key_valid, bus_if.key_code);
        else n_pass++;
    endtask

    task automatic test_repeat();
        int exp_p;
        do_reset();
        pulses = 0;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        n_total++;
        if (bus_if.key_held !== 1'b0)
            $display("FAIL repeat_release_held: got %b, want 0", bus_if.key_held);
        else n_pass++;
        idle(2);
        exp_p = FILTER ? 1 : 3;
        n_total++;
        if (pulses != exp_p)
            $display("FAIL repeat_pulse_count: got %0d, want %0d", pulses, exp_p);
        else n_pass++;
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h75);
        n_total++;
        if (bus_if.key_valid !== 1'b1 || bus_if.key_code !== 8'h75 ||
            bus_if.key_extended !== 1'b1 || bus_if.key_held !== 1'b1)
            $display("FAIL ext_make: got v=%b c=%h e=%b h=%b, want v=1 c=75 e=1 h=1",
                     bus_if.key_valid, bus_if.key_code, bus_if.key_extended, bus_if.key_held);
        else n_pass++;
        pulses = 0;
        send(8'hE0); send(8'hF0); send(8'h75);
        n_total++;
        if (bus_if.key_held !== 1'b0 || pulses != 0)
            $display("FAIL ext_break: got h=%b pulses=%0d, want h=0 pulses=0",
                     bus_if.key_held, pulses);
        else n_pass++;
        send(8'hE0); send(8'h12); send(8'hE0); send(8'hF0); send(8'h12);
        idle(1);
        n_total++;
        if (pulses != 0 || bus_if.key_held !== 1'b0 || bus_if.key_code !== 8'h75)
            $display("FAIL fake_shift: got pulses=%0d h=%b c=%h, want 0 0 75",
                     pulses, bus_if.key_held, bus_if.key_code);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hF0);
        idle(TMO);
        send(8'h29);
        n_total++;
        if (bus_if.key_valid !== 1'b1 || bus_if.key_code !== 8'h29 || bus_if.key_held !== 1'b1)
            $display("FAIL timeout_abandon: got v=%b c=%h h=%b, want v=1 c=29 h=1",
                     bus_if.key_valid, bus_if.key_code, bus_if.key_held);
        else n_pass++;
        // A short gap keeps the break prefix alive, so 29 is released
        pulses = 0;
        send(8'hF0);
        idle(TMO / 2);
        send(8'h29);
        n_total++;
        if (bus_if.key_held !== 1'b0 || pulses != 0)
            $display("FAIL timeout_short_gap: got h=%b pulses=%0d, want h=0 pulses=0",
                     bus_if.key_held, pulses);
        else n_pass++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        pulses = 0;
        foreach (seq[i]) send(seq[i]);
        idle(1);
        n_total++;
        if (pulses != 0)
            $display("FAIL pause_silent: got %0d pulses, want 0", pulses);
        else n_pass++;
        send(8'h1C);
        n_total++;
        if (bus_if.key_valid !== 1'b1 || bus_if.key_code !== 8'h1C || pulses != 1)
            $display("FAIL pause_then_make: got v=%b c=%h pulses=%0d, want 1 1c 1",
                     bus_if.key_valid, bus_if.key_code, pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        send(8'hF0);
        tick(1'b1, 1'b1, 8'h34);
        n_total++;
        if ({bus_if.key_valid, bus_if.key_code, bus_if.key_extended, bus_if.key_held} !== 11'h0)
            $display("FAIL reset_mid_outputs: got v=%b c=%h e=%b h=%b, want all 0",
                     bus_if.key_valid, bus_if.key_code, bus_if.key_extended, bus_if.key_held);
        else n_pass++;
        send(8'h34);
        n_total++;
        if (bus_if.key_valid !== 1'b1 || bus_if.key_code !== 8'h34 || bus_if.key_held !== 1'b1)
            $display("FAIL reset_mid_make: got v=%b c=%h h=%b, want v=1 c=34 h=1",
                     bus_if.key_valid, bus_if.key_code, bus_if.key_held);
        else n_pass++;
    endtask

    task automatic test_status();
        pulses = 0;
        send(8'hAA); send(8'hFA); send(8'hFE); send(8'h00); send(8'hFF); send(8'hFC);
        idle(1);
        n_total++;
        if (pulses != 0 || bus_if.key_code !== 8'h34)
            $display("FAIL status_drop: got pulses=%0d c=%h, want 0 34", pulses, bus_if.key_code);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] tbl [16];
        logic [7:0] b;
        logic       p;
        int         errs;
        tbl = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h12, 8'hE0, 8'hE0,
                8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'h29};
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                tick(1'b1, $urandom_range(0, 1) == 1, tbl[$urandom_range(0, 15)]);
            end else if ($urandom_range(0, 59) == 0) begin
                idle(TMO + 4);
            end else begin
                p = ($urandom_range(0, 3) != 0);
                b = tbl[$urandom_range(0, 15)];
                tick(1'b0, p, b);
            end
            n_total++;
            if (bus_if.key_valid !== m_valid || bus_if.key_code !== m_code ||
                bus_if.key_extended !== m_ext || bus_if.key_held !== m_held) begin
                if (errs < 10)
                    $display("FAIL random_step_%0d: got v=%b c=%h e=%b h=%b, want v=%b c=%h e=%b h=%b",
                             i, bus_if.key_valid, bus_if.key_code, bus_if.key_extended,
                             bus_if.key_held, m_valid, m_code, m_ext, m_held);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        bus_if.ps2_key_pressed = 1'b0;
        bus_if.ps2_key_data    = 8'h00;
        test_reset();
        test_single_make();
        test_repeat();
        test_extended();
        test_timeout();
        test_pause();
        test_reset_mid();
        test_status();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
